permute: RTL and testbench
==========================

Name: permute

Overview:
- Registered 32-bit bit-permutation unit for the DES datapath.
- Applies a selectable fixed permutation to a 32-bit word: identity, DES P-box, inverse P-box or bit-reverse.
- Follows it with a programmable left rotation.
- Sits between the S-box/round logic and the round XOR; also usable standalone for key/half-block shuffling.

Parameters:
- WIDTH, 32, data word width; fixed at 32 because the DES tables are 32-entry, and other values are unsupported.

Ports:
- clk   input   1   rising-edge clock
- rst   input   1   asynchronous, active-high reset
- key   input   32  data word to permute; bit 31 = DES bit 1 (MSB-first numbering)
- perm  input   8   command byte: [7] enable, [6:2] rotate-left amount (0-31), [1:0] mode
- dout  output  32  registered permuted/rotated result
- valid output  1   pulses high one cycle after each enabled command

Behaviour:
- Clock and reset: one clock (clk); reset is asynchronous and active-high (rst). On rst: dout=0x00000000, valid=0, asynchronously, regardless of clk.
- Mode perm[1:0]:
  - 00: identity.
  - 01: DES P-box. Output bit i (1-based, MSB first) = input bit P[i]. P = 16 7 20 21 29 12 28 17 1 15 23 26 5 18 31 10 2 8 24 14 32 27 3 9 19 13 30 6 22 11 4 25.
  - 10: inverse P-box, the exact inverse of the table above.
  - 11: bit-reverse, so output bit n = input bit 31-n.
- Rotation: after the mode permutation, the result is rotated left by perm[6:2] bits. An amount of 0 means no rotation.
- Both stages are purely combinational; the final result is captured into dout.
- Enable perm[7]=1 at a rising edge:
  - dout <= rotl(mode_perm(key), perm[6:2]);
  - valid <= 1.
  - Latency is one cycle, and back-to-back commands are accepted every cycle.
- Enable perm[7]=0 at a rising edge: dout holds its previous value; valid <= 0.
- valid is asserted only in the cycle directly following an enabled edge. A continuous enable keeps valid high.
- No handshake or backpressure; key and perm only need to be stable around the sampling edge.
- Reset asserted mid-stream: dout and valid clear immediately. The first enabled edge after rst deasserts produces a normal result.
- Reset has priority over enable at the same edge.
- All bit indices are modulo 32; there is no overflow or width growth.

Test Plan:
- Reset: assert rst with key=0xFFFFFFFF, perm=0x80 -> dout=0x00000000 and valid=0 while rst is high, even between clock edges.
- Identity plus rotate: key=0x12345678, perm=0x90 (enable, rot 4, mode 0) -> next cycle dout=0x23456781, valid=1. Then perm=0x00 -> dout holds 0x23456781, valid=0.
- P-box: key=0x80000000, perm=0x81 -> dout=0x00800000. Then inverse with key=0x00800000, perm=0x82 -> dout=0x80000000.
- Round-trip: for 16 random keys, apply P (0x81) and feed dout back with inverse P (0x82) -> dout equals the original key every time. Also check P(0xFFFFFFFF)=0xFFFFFFFF.
- Bit-reverse and max rotate: key=0x00000001, perm=0x83 -> 0x80000000. Then key=0x00000001, perm=0xFC (rot 31, identity) -> 0x80000000.
- Back-to-back and mid-stream reset: enable for 3 consecutive cycles with different keys -> valid stays high and each dout matches its preceding command. Pulse rst between edges -> outputs clear at once, and the next enabled command produces a correct result.

Source files
------------

// File: rtl/permute_if.sv
// permute_if: command/result bundle for the permute unit.
//   key   : 32-bit word to permute (bit 31 = DES bit 1)
//   perm  : command byte, [7] enable, [6:2] rotate-left amount, [1:0] mode
//   dout  : registered permuted/rotated result
//   valid : high for one cycle after each enabled command
// The master modport drives commands; the slave modport (permute) returns results.
interface permute_if #(
   parameter int unsigned WIDTH = 32
);
   logic [WIDTH-1:0] key;
   logic [7:0]       perm;
   logic [WIDTH-1:0] dout;
   logic             valid;

   modport master (
      output key,
      output perm,
      input  dout,
      input  valid
   );

   modport slave (
      input  key,
      input  perm,
      output dout,
      output valid
   );
endinterface

// File: rtl/permute.sv
// permute: registered 32-bit bit-permutation unit for the DES datapath.
// A fixed permutation chosen by perm[1:0] is applied to key, and the result is
// then rotated left by perm[6:2]. When perm[7] is high at a rising edge, the
// result is captured into dout and valid pulses the following cycle.
// Ports:
//   clk : rising-edge clock
//   rst : asynchronous active-high reset (clears dout and valid)
//   bus : permute_if slave (key, perm in; dout, valid out)
// Modes: 00 identity, 01 DES P-box, 10 inverse P-box, 11 bit-reverse.
module permute #(
   parameter int unsigned WIDTH = 32
) (
   input  logic         clk,
   input  logic         rst,
   permute_if.slave     bus
);

   typedef enum logic [1:0] {
      MODE_IDENT = 2'b00,
      MODE_PBOX  = 2'b01,
      MODE_INVP  = 2'b10,
      MODE_BREV  = 2'b11
   } mode_t;

   // DES P table, 1-based and MSB-first: output bit i takes input bit PTAB[i-1].
   localparam int unsigned PTAB [32] = '{
      16,  7, 20, 21, 29, 12, 28, 17,
       1, 15, 23, 26,  5, 18, 31, 10,
       2,  8, 24, 14, 32, 27,  3,  9,
      19, 13, 30,  6, 22, 11,  4, 25
   };

   // DES bit n (1-based, MSB-first) lives at vector index 32-n.
   function automatic logic [4:0] des_idx(input int unsigned n);
      return 5'(32 - n);
   endfunction

   function automatic logic [WIDTH-1:0] pbox(input logic [WIDTH-1:0] d);
      logic [WIDTH-1:0] r;
      r = '0;
      for (int unsigned i = 0; i < 32; i++) begin
         r[des_idx(i + 1)] = d[des_idx(PTAB[i])];
      end
      return r;
   endfunction

   // Inverse uses the same table with source and destination swapped,
   // which is exactly the inverse mapping since P is a bijection.
   function automatic logic [WIDTH-1:0] invpbox(input logic [WIDTH-1:0] d);
      logic [WIDTH-1:0] r;
      r = '0;
      for (int unsigned i = 0; i < 32; i++) begin
         r[des_idx(PTAB[i])] = d[des_idx(i + 1)];
      end
      return r;
   endfunction

   function automatic logic [WIDTH-1:0] bitrev(input logic [WIDTH-1:0] d);
      logic [WIDTH-1:0] r;
      r = '0;
      for (int unsigned i = 0; i < 32; i++) begin
         r[5'(i)] = d[5'(31 - i)];
      end
      return r;
   endfunction

   // Rotate-left via a doubled word: the upper half of {d,d} << n is rotl(d, n).
   function automatic logic [WIDTH-1:0] rotl(input logic [WIDTH-1:0] d,
                                             input logic [4:0]       n);
      logic [2*WIDTH-1:0] dbl;
      dbl = {d, d} << n;
      return dbl[2*WIDTH-1:WIDTH];
   endfunction

   mode_t            mode;
   logic             en;
   logic [4:0]       rot;
   logic [WIDTH-1:0] permuted;
   logic [WIDTH-1:0] result;

   assign en   = bus.perm[7];
   assign rot  = bus.perm[6:2];
   assign mode = mode_t'(bus.perm[1:0]);

   always_comb begin
      permuted = bus.key;
      unique case (mode)
         MODE_IDENT: permuted = bus.key;
         MODE_PBOX:  permuted = pbox(bus.key);
         MODE_INVP:  permuted = invpbox(bus.key);
         MODE_BREV:  permuted = bitrev(bus.key);
      endcase
   end

   always_comb begin
      result = rotl(permuted, rot);
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         bus.dout  <= '0;
         bus.valid <= 1'b0;
      end else begin
         bus.valid <= en;
         if (en) begin
            bus.dout <= result;
         end
      end
   end

endmodule

// File: tb/tb_permute.sv
// tb_permute: self-checking bench for permute.
module tb_permute;

   logic clk;
   logic rst;

   permute_if #(.WIDTH(32)) bus ();

   permute #(.WIDTH(32)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int checks = 0;
   int errors = 0;

   logic [31:0] sb [$];
   logic [31:0] held;

   // Reference P table, 1-based MSB-first, and its inverse built at start-up.
   int ptab [1:32];
   int pinv [1:32];

   typedef struct {
      logic [31:0] key;
      logic [7:0]  perm;
      logic [31:0] exp_dout;
      string       name;
   } vec_t;

   vec_t vecs [8];

   // DES bit n (1-based, MSB-first) of w.
   function automatic logic desbit(input logic [31:0] w, input int n);
      logic [31:0] t;
      t = w >> (32 - n);
      return t[0];
   endfunction

   function automatic logic [31:0] model(input logic [31:0] k, input logic [7:0] p);
      logic [31:0] r;
      logic [31:0] t;
      int          amt;
      r = '0;
      case (p[1:0])
         2'b00: r = k;
         2'b01: for (int i = 1; i <= 32; i++) r = {r[30:0], desbit(k, ptab[i])};
         2'b10: for (int i = 1; i <= 32; i++) r = {r[30:0], desbit(k, pinv[i])};
         default: begin
            t = k;
            for (int i = 0; i < 32; i++) begin
               r = {r[30:0], t[0]};
               t = t >> 1;
            end
         end
      endcase
      amt = int'(p[6:2]);
      for (int i = 0; i < amt; i++) r = {r[30:0], r[31]};
      return r;
   endfunction

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %08h expected %08h", name, act, exp);
      end
   endtask

   // Called at a negedge: drive a command, let one rising edge capture it,
   // then check valid and dout just after that edge.
   task automatic step(input string name, input logic [31:0] k,
                       input logic [7:0] p, input logic [31:0] exp_d);
      logic [31:0] e;
      bus.key  = k;
      bus.perm = p;
      if (p[7]) begin
         sb.push_back(exp_d);
         held = exp_d;
      end
      @(posedge clk);
      #1;
      chk({name, ".valid"}, {31'b0, bus.valid}, {31'b0, p[7]});
      if (p[7]) begin
         if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s.sb: scoreboard empty, got %08h", name, bus.dout);
         end else begin
            e = sb.pop_front();
            chk({name, ".dout"}, bus.dout, e);
         end
      end else begin
         chk({name, ".hold"}, bus.dout, held);
      end
      @(negedge clk);
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      logic [31:0] k;
      logic [31:0] pk;
      logic [7:0]  p;
      int          tmp [32];

      tmp = '{16, 7, 20, 21, 29, 12, 28, 17, 1, 15, 23, 26, 5, 18, 31, 10,
              2, 8, 24, 14, 32, 27, 3, 9, 19, 13, 30, 6, 22, 11, 4, 25};
      for (int i = 1; i <= 32; i++) ptab[i] = tmp[i-1];
      for (int i = 1; i <= 32; i++) pinv[ptab[i]] = i;

      vecs[0] = '{32'h12345678, 8'h90, 32'h23456781, "ident_rot4"};
      vecs[1] = '{32'h12345678, 8'h00, 32'h23456781, "hold"};
      vecs[2] = '{32'h80000000, 8'h81, 32'h00800000, "pbox_bit1"};
      vecs[3] = '{32'h00800000, 8'h82, 32'h80000000, "invp_bit9"};
      vecs[4] = '{32'hFFFFFFFF, 8'h81, 32'hFFFFFFFF, "pbox_ones"};
      vecs[5] = '{32'h00000001, 8'h83, 32'h80000000, "bitrev"};
      vecs[6] = '{32'h00000001, 8'hFC, 32'h80000000, "rot31"};
      vecs[7] = '{32'hABCDEF01, 8'h7F, 32'h80000000, "disabled"};

      // Reset with an enabled command present: outputs must stay clear.
      rst      = 1'b1;
      bus.key  = 32'hFFFFFFFF;
      bus.perm = 8'h80;
      held     = '0;
      #3;
      chk("rst_async.dout", bus.dout, 32'h0);
      chk("rst_async.valid", {31'b0, bus.valid}, 32'h0);
      @(posedge clk);
      #1;
      chk("rst_edge.dout", bus.dout, 32'h0);
      chk("rst_edge.valid", {31'b0, bus.valid}, 32'h0);
      @(negedge clk);
      chk("rst_mid.dout", bus.dout, 32'h0);
      bus.perm = 8'h00;
      rst      = 1'b0;

      foreach (vecs[i]) step(vecs[i].name, vecs[i].key, vecs[i].perm, vecs[i].exp_dout);

      // P followed by inverse P on the DUT's own output recovers the key.
      for (int i = 0; i < 16; i++) begin
         k = $urandom();
         step("rt_p", k, 8'h81, model(k, 8'h81));
         pk = bus.dout;
         step("rt_inv", pk, 8'h82, k);
      end

      // Random mixed commands, including disabled ones.
      for (int i = 0; i < 24; i++) begin
         k = $urandom();
         p = 8'($urandom());
         step("rand", k, p, model(k, p));
      end

      // Back-to-back enabled commands.
      step("b2b0", 32'hDEADBEEF, 8'h81, model(32'hDEADBEEF, 8'h81));
      step("b2b1", 32'h0F0F1234, 8'hAB, model(32'h0F0F1234, 8'hAB));
      step("b2b2", 32'hCAFEF00D, 8'hC6, model(32'hCAFEF00D, 8'hC6));

      // Reset pulse between edges clears outputs without waiting for clk.
      step("pre_rst", 32'h13579BDF, 8'h97, model(32'h13579BDF, 8'h97));
      bus.perm = 8'h00;
      #2;
      rst = 1'b1;
      #1;
      chk("midrst.dout", bus.dout, 32'h0);
      chk("midrst.valid", {31'b0, bus.valid}, 32'h0);
      #1;
      rst  = 1'b0;
      held = '0;
      @(negedge clk);
      step("post_rst_idle", 32'h11111111, 8'h00, 32'h0);
      step("post_rst", 32'h2468ACE0, 8'h8D, model(32'h2468ACE0, 8'h8D));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
